// File: rtl/bn_seq_pkg.sv
// -----------------------------------------------------------------------------
// bn_seq_pkg
// Shared definitions for the batch-norm layer sequencer:
//   - FSM state encoding
//   - bit positions of the PS control word (ps_control) and the PL status
//     word (pl_status)
//   - channel-count clamp helper
// -----------------------------------------------------------------------------
package bn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } bn_seq_state_e;

  // ps_control bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_CH_LSB = 8;
  localparam int CTRL_CH_MSB = 15;

  // pl_status bit positions
  localparam int STAT_DONE    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_CH_LSB  = 8;
  localparam int STAT_CH_MSB  = 15;

  // A requested count of 0, or one above the hardware maximum, means
  // "run every channel".
  function automatic logic [7:0] clamp_ch_cnt(input logic [7:0] req, input int max_ch);
    if (req == 8'd0 || int'(req) > max_ch) return 8'(max_ch);
    return req;
  endfunction

endpackage

// File: rtl/bn_seq_watchdog.sv
// -----------------------------------------------------------------------------
// bn_seq_watchdog
// Loadable down-counter used as the engine timeout. Loading doubles as the
// clear; the count decrements while enabled and saturates at zero.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   i_load     in   reload the counter with i_load_val (clear)
//   i_load_val in   reload value
//   i_en       in   decrement enable
//   o_expired  out  counter has reached zero
// -----------------------------------------------------------------------------
module bn_seq_watchdog #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/bn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// bn_layer_sequencer
// Runs the single-channel batch-norm engine once per channel of a layer:
// one eng_start per channel with that channel's byte base address, waiting
// for eng_done between channels, and reporting progress to the PS.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   ps_control     in   [0] start (edge), [1] abort, [15:8] channel count
//   pl_status      out  [0] done, [1] busy, [2] timeout, [3] aborted,
//                       [15:8] current channel
//   eng_start      out  one-cycle engine start pulse
//   eng_base_addr  out  byte base address of the current channel
//   eng_done       in   engine completion (pulse or level)
//
// Build option
//   BN_SEQ_WATCHDOG_EN : when defined, a WDOG_CYCLES timeout ends a stalled
//                        WAIT and sets the timeout status bit.
// -----------------------------------------------------------------------------
module bn_layer_sequencer
  import bn_seq_pkg::*;
#(
  parameter int          NUM_CH      = 8,
  parameter int          CH_WORDS    = 16,
  parameter int          BYTE_OFFSET = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic        eng_start,
  output logic [31:0] eng_base_addr,
  input  logic        eng_done
);

  localparam logic [31:0] CH_STRIDE = 32'(CH_WORDS * BYTE_OFFSET);

  bn_seq_state_e r_state, w_state_next;
  logic [7:0]    r_ch, r_ch_cnt;
  logic          r_start_q, r_abort, r_timeout;
  logic [31:0]   r_base_addr;

  logic          w_start_rise, w_last_ch, w_abort_now, w_wdog_expired;
  logic          w_unused_ctl;

  assign w_start_rise = ps_control[CTRL_START] & ~r_start_q;
  assign w_last_ch    = (r_ch == r_ch_cnt - 8'd1);
  // An abort arriving in the same cycle as eng_done still stops the layer.
  assign w_abort_now  = r_abort | ps_control[CTRL_ABORT];
  assign w_unused_ctl = ^{ps_control[31:16], ps_control[7:2]};

`ifdef BN_SEQ_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  bn_seq_watchdog #(.WIDTH(WDOG_W)) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ST_LAUNCH),
    .i_load_val (WDOG_W'(WDOG_CYCLES - 1)),
    .i_en       (r_state == ST_WAIT),
    .o_expired  (w_wdog_expired)
  );
`else
  assign w_wdog_expired = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start_rise) w_state_next = ST_LAUNCH;
      ST_LAUNCH: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // eng_done wins over a watchdog expiry in the same cycle.
        if (eng_done) w_state_next = (w_last_ch || w_abort_now) ? ST_DONE : ST_NEXT;
        else if (w_wdog_expired) w_state_next = ST_DONE;
      end
      ST_NEXT:   w_state_next = ST_LAUNCH;
      ST_DONE:   if (!ps_control[CTRL_START]) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_ch        <= 8'd0;
      r_ch_cnt    <= 8'd0;
      r_abort     <= 1'b0;
      r_timeout   <= 1'b0;
      r_base_addr <= BASE_ADDR;
    end else begin
      r_start_q <= ps_control[CTRL_START];
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_ch_cnt    <= clamp_ch_cnt(ps_control[CTRL_CH_MSB:CTRL_CH_LSB], NUM_CH);
            r_ch        <= 8'd0;
            r_abort     <= 1'b0;
            r_timeout   <= 1'b0;
            r_base_addr <= BASE_ADDR;
          end
        end
        ST_LAUNCH: begin
          if (ps_control[CTRL_ABORT]) r_abort <= 1'b1;
        end
        ST_WAIT: begin
          if (ps_control[CTRL_ABORT]) r_abort <= 1'b1;
          if (!eng_done && w_wdog_expired) r_timeout <= 1'b1;
        end
        ST_NEXT: begin
          if (ps_control[CTRL_ABORT]) r_abort <= 1'b1;
          r_ch        <= r_ch + 8'd1;
          // Incremental add equals BASE_ADDR + ch*stride modulo 2^32.
          r_base_addr <= r_base_addr + CH_STRIDE;
        end
        default: ;
      endcase
    end
  end

  assign eng_start     = (r_state == ST_LAUNCH);
  assign eng_base_addr = r_base_addr;

  always_comb begin
    pl_status                          = '0;
    pl_status[STAT_DONE]               = (r_state == ST_DONE);
    pl_status[STAT_BUSY]               = (r_state == ST_LAUNCH) || (r_state == ST_WAIT) ||
                                         (r_state == ST_NEXT);
    pl_status[STAT_TIMEOUT]            = r_timeout;
    pl_status[STAT_ABORTED]            = r_abort;
    pl_status[STAT_CH_MSB:STAT_CH_LSB] = r_ch;
  end

endmodule

// File: tb/tb_bn_layer_sequencer.sv
module tb_bn_layer_sequencer;

  localparam int          NUM_CH = 8;
  localparam logic [31:0] STRIDE = 32'd64;   // 16 words * 4 bytes

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ps_control = 32'd0;
  logic [31:0] pl_status;
  logic        eng_start;
  logic [31:0] eng_base_addr;
  logic        eng_done = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bn_layer_sequencer #(
    .NUM_CH      (NUM_CH),
    .CH_WORDS    (16),
    .BYTE_OFFSET (4),
    .BASE_ADDR   (32'd0),
    .WDOG_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ps_control    (ps_control),
    .pl_status     (pl_status),
    .eng_start     (eng_start),
    .eng_base_addr (eng_base_addr),
    .eng_done      (eng_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (eng_start === 1'b1) found = 1'b1;
      else tick();
    end
  endtask

  task automatic pulse_done(input int lat);
    repeat (lat) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps_control = 32'd0; eng_done = 1'b0;
    tick(); tick();
    n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", eng_start); end
    n_cmp++; if (eng_base_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", eng_base_addr); end
    n_cmp++; if (pl_status !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h want 0", pl_status); end
    reset = 1'b0;
    tick();
    n_cmp++; if (pl_status !== 32'd0) begin n_err++; $display("FAIL reset_release_status: got %h want 0", pl_status); end
  endtask

  task automatic test_three_channels();
    ps_control = 32'h0000_0301;
    tick();
    for (int ch = 0; ch < 3; ch++) begin
      n_cmp++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL three_start_ch%0d: got %b want 1", ch, eng_start); end
      n_cmp++; if (eng_base_addr !== 32'(ch) * STRIDE) begin n_err++; $display("FAIL three_addr_ch%0d: got %h want %h", ch, eng_base_addr, 32'(ch) * STRIDE); end
      n_cmp++; if (pl_status !== {16'h0, 8'(ch), 8'h02}) begin n_err++; $display("FAIL three_busy_ch%0d: got %h want %h", ch, pl_status, {16'h0, 8'(ch), 8'h02}); end
      // Changing the count field mid-run must not shorten the layer.
      if (ch == 0) ps_control = 32'h0000_0101;
      tick();
      n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL three_pulse_ch%0d: got %b want 0", ch, eng_start); end
      pulse_done(18);
      if (ch < 2) begin
        n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL three_gap_ch%0d: got %b want 0", ch, eng_start); end
        tick();
      end
    end
    n_cmp++; if (pl_status !== 32'h0000_0201) begin n_err++; $display("FAIL three_done: got %h want 00000201", pl_status); end
    ps_control = 32'd0;
    tick();
    n_cmp++; if (pl_status !== 32'h0000_0200) begin n_err++; $display("FAIL three_idle: got %h want 00000200", pl_status); end
  endtask

  task automatic test_count_clamp();
    bit found;
    logic [7:0] req [2];
    req[0] = 8'd0; req[1] = 8'd9;
    for (int r = 0; r < 2; r++) begin
      ps_control = {16'h0, req[r], 8'h01};
      tick();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        wait_start(6, found);
        n_cmp++; if (!found) begin n_err++; $display("FAIL clamp_req%0d_start_ch%0d: no start within 6 cycles", req[r], ch); end
        n_cmp++; if (eng_base_addr !== 32'(ch) * STRIDE) begin n_err++; $display("FAIL clamp_req%0d_addr_ch%0d: got %h want %h", req[r], ch, eng_base_addr, 32'(ch) * STRIDE); end
        tick();
        pulse_done(1);
      end
      n_cmp++; if (pl_status !== 32'h0000_0701) begin n_err++; $display("FAIL clamp_req%0d_done: got %h want 00000701", req[r], pl_status); end
      n_cmp++; if (eng_base_addr !== 32'd448) begin n_err++; $display("FAIL clamp_req%0d_last_addr: got %h want 000001c0", req[r], eng_base_addr); end
      ps_control = 32'd0;
      tick();
    end
  endtask

  task automatic test_abort();
    bit found;
    int starts;
    ps_control = 32'h0000_0401;
    tick();
    wait_start(4, found);
    tick();
    pulse_done(2);
    wait_start(4, found);
    n_cmp++; if (!found || eng_base_addr !== 32'd64) begin n_err++; $display("FAIL abort_ch1_start: found %b addr %h want 1 / 00000040", found, eng_base_addr); end
    tick();
    ps_control[1] = 1'b1;
    tick();
    ps_control[1] = 1'b0;
    pulse_done(3);
    n_cmp++; if (pl_status !== 32'h0000_0109) begin n_err++; $display("FAIL abort_status: got %h want 00000109", pl_status); end
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (eng_start === 1'b1) starts++;
      tick();
    end
    n_cmp++; if (starts !== 0) begin n_err++; $display("FAIL abort_no_launch: got %0d starts want 0", starts); end
    n_cmp++; if (pl_status !== 32'h0000_0109) begin n_err++; $display("FAIL abort_hold: got %h want 00000109", pl_status); end
    ps_control = 32'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    // eng_done held high from the LAUNCH cycle: ignored in LAUNCH, taken in WAIT.
    ps_control = 32'h0000_0201;
    tick();
    n_cmp++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL b2b_start0: got %b want 1", eng_start); end
    eng_done = 1'b1;
    tick();
    n_cmp++; if (pl_status !== 32'h0000_0002) begin n_err++; $display("FAIL b2b_wait0: got %h want 00000002", pl_status); end
    tick();
    n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL b2b_next_gap: got %b want 0", eng_start); end
    tick();
    n_cmp++; if (eng_start !== 1'b1 || eng_base_addr !== 32'd64) begin n_err++; $display("FAIL b2b_start1: start %b addr %h want 1 / 00000040", eng_start, eng_base_addr); end
    tick(); tick();
    n_cmp++; if (pl_status !== 32'h0000_0101) begin n_err++; $display("FAIL b2b_done: got %h want 00000101", pl_status); end
    eng_done = 1'b0;
    ps_control = 32'd0;
    tick();
  endtask

  task automatic test_hold_start();
    ps_control = 32'h0000_0101;
    tick();
    tick();
    pulse_done(1);
    n_cmp++; if (pl_status !== 32'h0000_0001) begin n_err++; $display("FAIL hold_done: got %h want 00000001", pl_status); end
    repeat (30) tick();
    n_cmp++; if (pl_status !== 32'h0000_0001) begin n_err++; $display("FAIL hold_held: got %h want 00000001", pl_status); end
    ps_control = 32'd0;
    tick();
    n_cmp++; if (pl_status !== 32'h0000_0000 || eng_start !== 1'b0) begin n_err++; $display("FAIL hold_idle: status %h start %b want 00000000 / 0", pl_status, eng_start); end
    ps_control = 32'h0000_0101;
    tick();
    n_cmp++; if (eng_start !== 1'b1 || eng_base_addr !== 32'd0 || pl_status !== 32'h0000_0002) begin n_err++; $display("FAIL hold_relaunch: start %b addr %h status %h want 1 / 0 / 00000002", eng_start, eng_base_addr, pl_status); end
    tick();
    pulse_done(1);
    ps_control = 32'd0;
    tick();
  endtask

  task automatic test_reset_midrun();
    bit found;
    int starts;
    ps_control = 32'h0000_0401;
    tick();
    for (int ch = 0; ch < 2; ch++) begin
      wait_start(4, found);
      tick();
      pulse_done(2);
    end
    wait_start(4, found);
    n_cmp++; if (!found || eng_base_addr !== 32'd128) begin n_err++; $display("FAIL midrst_ch2: found %b addr %h want 1 / 00000080", found, eng_base_addr); end
    tick(); tick();
    #2;
    reset = 1'b1;
    ps_control = 32'd0;
    #1;
    n_cmp++; if (pl_status !== 32'd0 || eng_start !== 1'b0 || eng_base_addr !== 32'd0) begin n_err++; $display("FAIL midrst_async: status %h start %b addr %h want all 0", pl_status, eng_start, eng_base_addr); end
    tick();
    reset = 1'b0;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (eng_start === 1'b1) starts++;
      tick();
    end
    n_cmp++; if (starts !== 0 || pl_status !== 32'd0) begin n_err++; $display("FAIL midrst_stray_done: starts %0d status %h want 0 / 00000000", starts, pl_status); end
  endtask

`ifdef BN_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    bit found;
    int cycles;
    ps_control = 32'h0000_0201;
    tick();
    tick();
    pulse_done(2);
    wait_start(4, found);
    cycles = 0;
    while (pl_status[0] !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    n_cmp++; if (cycles < 95 || cycles > 110) begin n_err++; $display("FAIL wdog_latency: got %0d cycles want about 100", cycles); end
    n_cmp++; if (pl_status !== 32'h0000_0105) begin n_err++; $display("FAIL wdog_status: got %h want 00000105", pl_status); end
    ps_control = 32'd0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_three_channels();
    test_count_clamp();
    test_abort();
    test_back_to_back();
    test_hold_start();
    test_reset_midrun();
`ifdef BN_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
